shift_mix_stage: RTL and testbench

Registered round stage directly downstream of the SubBytes stage in the AES cipher datapath.
- Accepts the substituted state and applies ShiftRows.
- Applies MixColumns unless the beat is tagged as the final round.
- Presents the result to AddRoundKey through a valid/ready handshake.
- Breaks the combinational path SubBytes→ShiftRows→MixColumns→AddRoundKey and provides backpressure.

---
 rtl/shift_mix_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_shift_mix_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_mix_stage.sv
// -----------------------------------------------------------------------------
// shift_mix_stage
//
// Registered AES round stage that sits between SubBytes and AddRoundKey.
// It applies ShiftRows to the incoming state and then MixColumns, unless the
// beat is tagged as the final round. The result is registered and handed on
// through a valid/ready handshake. This stage breaks the long combinational
// path SubBytes -> ShiftRows -> MixColumns -> AddRoundKey and carries
// backpressure from downstream to upstream.
//
// Build option:
//   SHIFT_MIX_STAGE_SKID_EN  When defined, a second (skid) register is added.
//                            in_ready then comes from a flop ("skid empty")
//                            and has no combinational path from out_ready.
//                            The stage holds up to 2 beats.
//                            When undefined, there is a single register.
//                            in_ready = !full || out_ready, and the stage
//                            holds 1 beat.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat this cycle
//   in_state   substituted state from SubBytes, byte = in_state[col][row]
//   in_round   round tag of the beat (ROUND_W bits)
//   in_last    final round: bypass MixColumns
//   out_valid  result beat valid
//   out_ready  downstream accepts
//   out_state  transformed state, same [col][row] indexing
//   out_round  round tag, passed through unchanged
//   out_last   last flag, passed through unchanged
// -----------------------------------------------------------------------------
module shift_mix_stage #(
  parameter int ROUND_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0][3:0][7:0]     in_state,
  input  logic [ROUND_W-1:0]       in_round,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0][3:0][7:0]     out_state,
  output logic [ROUND_W-1:0]       out_round,
  output logic                     out_last
);

  typedef logic [3:0][3:0][7:0] state_t;
  typedef logic [3:0][7:0]      column_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers
  // ---------------------------------------------------------------------------

  // Multiply by 2 modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // Row r rotates left by r columns: sr[c][r] = s[(c + r) mod 4][r].
  // The 2-bit source index wraps naturally, which gives the mod 4.
  function automatic state_t shift_rows(input state_t s);
    state_t     sr;
    logic [1:0] src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src      = 2'(c + r);
        sr[c][r] = s[src][r];
      end
    end
    return sr;
  endfunction

  function automatic column_t mix_column(input column_t s);
    column_t o;
    o[0] = xtime(s[0]) ^ mul3(s[1])  ^ s[2]        ^ s[3];
    o[1] = s[0]        ^ xtime(s[1]) ^ mul3(s[2])  ^ s[3];
    o[2] = s[0]        ^ s[1]        ^ xtime(s[2]) ^ mul3(s[3]);
    o[3] = mul3(s[0])  ^ s[1]        ^ s[2]        ^ xtime(s[3]);
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t m;
    for (int c = 0; c < 4; c++) begin
      m[c] = mix_column(s[c]);
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Input side: full transform of the incoming beat
  // ---------------------------------------------------------------------------
  state_t sr_state;
  state_t xf_state;

  always_comb begin
    sr_state = shift_rows(in_state);
    xf_state = in_last ? sr_state : mix_columns(sr_state);
  end

  // ---------------------------------------------------------------------------
  // Main output register
  // ---------------------------------------------------------------------------
  logic               full_q,  full_d;
  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               last_q,  last_d;

  logic in_xfer;
  logic out_xfer;

  // While rst is high, out_valid is forced low so that no output transfer
  // can happen in that cycle.
  assign out_valid = full_q && !rst;
  assign out_state = state_q;
  assign out_round = round_q;
  assign out_last  = last_q;

  assign out_xfer  = out_valid && out_ready;
  assign in_xfer   = in_valid && in_ready;

`ifdef SHIFT_MIX_STAGE_SKID_EN

  // ---------------------------------------------------------------------------
  // Skid register: catches the beat that arrives in the cycle when the main
  // register is stalled. It only fills while the main register is full, and
  // it drains into the main register on the next output transfer.
  // ---------------------------------------------------------------------------
  logic               skid_full_q,  skid_full_d;
  state_t             skid_state_q, skid_state_d;
  logic [ROUND_W-1:0] skid_round_q, skid_round_d;
  logic               skid_last_q,  skid_last_d;

  // in_ready comes straight from a flop. The only other term is the reset
  // gate, which holds it low while rst is high.
  assign in_ready = !skid_full_q && !rst;

  always_comb begin
    full_d       = full_q;
    state_d      = state_q;
    round_d      = round_q;
    last_d       = last_q;
    skid_full_d  = skid_full_q;
    skid_state_d = skid_state_q;
    skid_round_d = skid_round_q;
    skid_last_d  = skid_last_q;

    if (!full_q || out_xfer) begin
      // Main register is free this edge. The oldest beat moves in first:
      // the skid contents if there are any, otherwise the new beat.
      // in_ready is low while the skid is full, so both cannot compete.
      if (skid_full_q) begin
        full_d      = 1'b1;
        state_d     = skid_state_q;
        round_d     = skid_round_q;
        last_d      = skid_last_q;
        skid_full_d = 1'b0;
      end else if (in_xfer) begin
        full_d  = 1'b1;
        state_d = xf_state;
        round_d = in_round;
        last_d  = in_last;
      end else begin
        full_d  = 1'b0;
      end
    end else if (in_xfer) begin
      // Main register is stalled, so the arriving beat parks in the skid.
      skid_full_d  = 1'b1;
      skid_state_d = xf_state;
      skid_round_d = in_round;
      skid_last_d  = in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full_q  <= 1'b0;
      skid_state_q <= '0;
      skid_round_q <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      skid_full_q  <= skid_full_d;
      skid_state_q <= skid_state_d;
      skid_round_q <= skid_round_d;
      skid_last_q  <= skid_last_d;
    end
  end

`else

  // Single register: backpressure passes straight through to upstream.
  assign in_ready = (!full_q || out_ready) && !rst;

  always_comb begin
    full_d  = full_q;
    state_d = state_q;
    round_d = round_q;
    last_d  = last_q;

    // A simultaneous load and unload keeps full set and takes the new beat.
    if (in_xfer) begin
      full_d  = 1'b1;
      state_d = xf_state;
      round_d = in_round;
      last_d  = in_last;
    end else if (out_xfer) begin
      full_d  = 1'b0;
    end
  end

`endif

  // ---------------------------------------------------------------------------
  // Main register update. Data is cleared on reset so the output reads zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      state_q <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      state_q <= state_d;
      round_q <= round_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_shift_mix_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_mix_stage
//
// Self-checking bench for shift_mix_stage. It uses directed vectors from a
// table, hand-written backpressure and reset sequences, and a randomized
// valid/ready run. Expected results come from a GF(2^8) matrix model.
// Compile with +define+SHIFT_MIX_STAGE_SKID_EN to check the skid build.
// -----------------------------------------------------------------------------
module tb_shift_mix_stage;

  typedef logic [3:0][3:0][7:0] state_t;

  typedef struct packed {
    state_t     st;
    logic [3:0] rd;
    logic       ls;
  } beat_t;

  typedef struct {
    state_t     st;
    logic [3:0] rd;
    logic       ls;
    state_t     exp;
  } vec_t;

`ifdef SHIFT_MIX_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  state_t     in_state;
  logic [3:0] in_round;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  state_t     out_state;
  logic [3:0] out_round;
  logic       out_last;

  shift_mix_stage #(.ROUND_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_round  (in_round),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  beat_t  exp_q[$];
  logic   hold_prev = 1'b0;
  state_t prev_state;
  logic   ir_seen;
  int     outs_seen;

  // ---------------------------------------------------------------------------
  // Comparison helpers
  // ---------------------------------------------------------------------------
  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_r(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string nm, input state_t act, input state_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: generic GF(2^8) product and MixColumns coefficient matrix
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic state_t model(input state_t s, input logic last);
    state_t     sr, o;
    logic [7:0] cf [4];
    cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[c][r] = s[(c + r) % 4][r];
    if (last) return sr;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[c][r] = 8'h00;
        for (int k = 0; k < 4; k++)
          o[c][r] = o[c][r] ^ gmul(cf[(k - r + 4) % 4], sr[c][k]);
      end
    return o;
  endfunction

  // Build a state from four column words, row 0 in the top byte.
  function automatic state_t cols(input logic [31:0] c0, input logic [31:0] c1,
                                  input logic [31:0] c2, input logic [31:0] c3);
    state_t      s;
    logic [31:0] w [4];
    w = '{c0, c1, c2, c3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[c][r] = w[c][31 - 8*r -: 8];
    return s;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[c][r] = 8'($urandom);
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // One clock cycle with the scoreboard. Entered and left at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic vi, input state_t st, input logic [3:0] rd,
                      input logic ls, input logic ordy);
    beat_t e;
    in_valid  = vi;
    in_state  = st;
    in_round  = rd;
    in_last   = ls;
    out_ready = ordy;
    #1;
    ir_seen = in_ready;
    if (hold_prev) begin
      chk_b("hold_valid", out_valid, 1'b1);
      chk_s("hold_state", out_state, prev_state);
    end
    if (out_valid && out_ready) begin
      outs_seen++;
      if (exp_q.size() == 0) begin
        chk_b("unexpected_out", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk_s("out_state", out_state, e.st);
        chk_r("out_round", out_round, e.rd);
        chk_b("out_last", out_last, e.ls);
      end
    end
    if (vi && in_ready) begin
      e.st = model(st, ls);
      e.rd = rd;
      e.ls = ls;
      exp_q.push_back(e);
    end
    hold_prev  = out_valid && !out_ready;
    prev_state = out_state;
    @(negedge clk);
  endtask

  vec_t   vt [5];
  state_t idx_st, idx_exp;
  int     sent, cyc;
  logic   vi_r;
  logic [3:0] tag;

  initial begin
    // ---------------------------------------------------------------------
    // Directed vectors
    // ---------------------------------------------------------------------
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        idx_st[c][r]  = 8'(c*4 + r);
        idx_exp[c][r] = 8'(((c + r) % 4)*4 + r);
      end
    vt[0] = '{cols(32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230), 4'd1, 1'b0,
              cols(32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c)};
    vt[1] = '{cols(32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230), 4'd10, 1'b1,
              cols(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5)};
    vt[2] = '{cols(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080), 4'd3, 1'b0,
              cols(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080)};
    vt[3] = '{idx_st, 4'd14, 1'b1, idx_exp};
    vt[4] = '{'0, 4'd5, 1'b0, '0};

    // ---------------------------------------------------------------------
    // Reset
    // ---------------------------------------------------------------------
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_round = '0; in_last = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_b("post_rst_out_valid", out_valid, 1'b0);
    chk_s("post_rst_out_state", out_state, '0);
    chk_r("post_rst_out_round", out_round, 4'd0);
    chk_b("post_rst_out_last", out_last, 1'b0);
    chk_b("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // ---------------------------------------------------------------------
    // Table: single beats, latency 1
    // ---------------------------------------------------------------------
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_state = vt[i].st; in_round = vt[i].rd; in_last = vt[i].ls;
      out_ready = 1'b1;
      #1;
      chk_b("tbl_in_ready", in_ready, 1'b1);
      chk_b("tbl_idle_valid", out_valid, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk_b("tbl_out_valid", out_valid, 1'b1);
      chk_s("tbl_out_state", out_state, vt[i].exp);
      chk_r("tbl_out_round", out_round, vt[i].rd);
      chk_b("tbl_out_last", out_last, vt[i].ls);
      @(negedge clk);
      #1;
      chk_b("tbl_drained", out_valid, 1'b0);
      @(negedge clk);
    end

    // ---------------------------------------------------------------------
    // Back-to-back 8 beats, then 3 stalled cycles, then release
    // ---------------------------------------------------------------------
    outs_seen = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, rand_state(), 4'(k), 1'b0, 1'b1);
      chk_b("b2b_in_ready", ir_seen, 1'b1);
    end
    chk_r("b2b_outs", 4'(outs_seen), 4'd7);
    for (int h = 0; h < 3; h++) begin
      step(1'b1, rand_state(), 4'(8 + h), 1'b1, 1'b0);
      chk_b("stall_in_ready", ir_seen, (CAP == 2) && (h == 0));
    end
    outs_seen = 0;
    for (int k = 0; k < 4; k++) step(1'b0, '0, 4'd0, 1'b0, 1'b1);
    chk_r("stall_drain_outs", 4'(outs_seen), 4'(CAP));
    chk_b("stall_drain_empty", exp_q.size() == 0, 1'b1);

    // ---------------------------------------------------------------------
    // Reset while beats are held
    // ---------------------------------------------------------------------
    for (int k = 0; k < 3; k++) step(1'b1, rand_state(), 4'(12 + k), 1'b0, 1'b0);
    chk_b("fill_in_ready", ir_seen, 1'b0);
    chk_b("fill_count", exp_q.size() == CAP, 1'b1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk_b("mid_rst_in_ready", in_ready, 1'b0);
    chk_b("mid_rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk_b("mid_post_out_valid", out_valid, 1'b0);
    chk_s("mid_post_out_state", out_state, '0);
    chk_r("mid_post_out_round", out_round, 4'd0);
    chk_b("mid_post_in_ready", in_ready, 1'b1);
    exp_q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    outs_seen = 0;
    for (int k = 0; k < 4; k++) step(1'b0, '0, 4'd0, 1'b0, 1'b1);
    chk_r("mid_no_ghost", 4'(outs_seen), 4'd0);

    // ---------------------------------------------------------------------
    // Randomized valid/ready, 1000 beats
    // ---------------------------------------------------------------------
    sent = 0; cyc = 0; tag = 4'd0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      vi_r = (sent < 1000) && ($urandom_range(0, 9) < 7);
      step(vi_r, rand_state(), tag, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 6));
      if (vi_r && ir_seen) begin
        sent++;
        tag = tag + 4'd1;
      end
      cyc++;
    end
    chk_b("rand_completed", cyc < 20000, 1'b1);
    chk_b("rand_queue_empty", exp_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
